// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: stalls, bubbles,
// redirects, EX operand forwarding, halt drain and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_halt,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wrenable,
  input  logic              ex_mem_to_reg,
  input  logic              ex_jump_taken,
  input  logic              mem_valid,
  input  logic              mem_reg_wrenable,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_busy,
  input  logic              wb_valid,
  input  logic              wb_reg_wrenable,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           r_state, w_state_nxt;
  logic [DCW-1:0]   r_dcnt, w_dcnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_stall;
  logic             w_redirect;
  logic             w_load_use;
  logic             w_unused;

  // The load flag alone identifies a load; the write-enable is not needed here.
  assign w_unused = ex_reg_wrenable;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              m_v,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_v,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    if (m_v && m_we && (m_rd != '0) && (m_rd == rs))
      return 2'b10;
    else if (w_v && w_we && (w_rd != '0) && (w_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_redirect = ex_jump_taken && ex_valid;
  assign w_load_use = ex_valid && ex_mem_to_reg && (ex_rd != '0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    halted      = 1'b0;
    fwd_a       = fwd_sel(ex_rs1, mem_valid, mem_reg_wrenable, mem_rd,
                          wb_valid, wb_reg_wrenable, wb_rd);
    fwd_b       = fwd_sel(ex_rs2, mem_valid, mem_reg_wrenable, mem_rd,
                          wb_valid, wb_reg_wrenable, wb_rd);
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_stall     = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end else begin
      case (r_state)
        S_RUN: begin
          if (mem_busy) begin
            w_stall = 1'b1;
          end else if (w_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
          end else if (w_load_use) begin
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            w_stall     = 1'b1;
          end else if (id_valid && id_halt) begin
            // HALT moves on to EX while fetch is cut off behind it.
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            ex_mem_en   = 1'b1;
            w_state_nxt = S_DRAIN;
            w_dcnt_nxt  = '0;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            ex_mem_en = 1'b1;
          end
        end
        S_DRAIN: begin
          if (mem_busy) begin
            w_stall = 1'b1;
          end else begin
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            ex_mem_en   = 1'b1;
            w_dcnt_nxt  = r_dcnt + 1'b1;
            if (r_dcnt == DCW'(DRAIN_CYCLES - 1))
              w_state_nxt = S_HALTED;
          end
        end
        S_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  // State, drain counter and stall counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_dcnt         <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      if (w_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard
// checked mid-cycle by an independent monitor.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, fwd_a, fwd_b, halted}
  localparam logic [9:0] C_RUN  = 10'b11001_00_00_0;
  localparam logic [9:0] C_FRZ  = 10'b00000_00_00_0;
  localparam logic [9:0] C_RED  = 10'b11111_00_00_0;
  localparam logic [9:0] C_LU   = 10'b00011_00_00_0;
  localparam logic [9:0] C_HACC = 10'b01101_00_00_0;
  localparam logic [9:0] C_DRN  = 10'b01101_00_00_0;
  localparam logic [9:0] C_DFZ  = 10'b00000_00_00_0;
  localparam logic [9:0] C_HLT  = 10'b00000_00_00_1;
  localparam logic [9:0] C_RST  = 10'b00110_00_00_0;
  localparam logic [9:0] F_A10  = 10'b00000_10_00_0;
  localparam logic [9:0] F_A01  = 10'b00000_01_00_0;
  localparam logic [9:0] F_B01  = 10'b00000_00_01_0;
  localparam logic [9:0] M_ALL  = 10'b11111_11_11_1;
  localparam logic [9:0] M_NIE  = 10'b10111_11_11_1;
  localparam logic [9:0] M_DRN  = 10'b10101_11_11_1;
  localparam logic [9:0] M_DFZ  = 10'b11001_11_11_1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_halt;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_valid, ex_reg_wrenable, ex_mem_to_reg, ex_jump_taken;
  logic mem_valid, mem_reg_wrenable, mem_busy, wb_valid, wb_reg_wrenable;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    string      nm;
    logic [9:0] ctl;
    logic [9:0] mask;
    int         stall;
    bit         schk;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_wrenable(ex_reg_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_jump_taken(ex_jump_taken),
    .mem_valid(mem_valid), .mem_reg_wrenable(mem_reg_wrenable), .mem_rd(mem_rd),
    .mem_busy(mem_busy),
    .wb_valid(wb_valid), .wb_reg_wrenable(wb_reg_wrenable), .wb_rd(wb_rd),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cycles(stall_cycles)
  );

  // Monitor: combinational outputs are settled mid-cycle
  always @(negedge clk) begin
    logic [9:0] act;
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, fwd_a, fwd_b, halted};
      n_chk++;
      if (((act ^ e_mon.ctl) & e_mon.mask) != 10'd0) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b (mask %b)", e_mon.nm, act, e_mon.ctl, e_mon.mask);
      end
      if (e_mon.schk) begin
        n_chk++;
        if (int'(stall_cycles) != e_mon.stall) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", e_mon.nm, stall_cycles, e_mon.stall);
        end
      end
    end
  end

  task automatic clear_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt = 0;
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_reg_wrenable = 0; ex_mem_to_reg = 0; ex_jump_taken = 0;
    mem_valid = 0; mem_reg_wrenable = 0; mem_rd = 0; mem_busy = 0;
    wb_valid = 0; wb_reg_wrenable = 0; wb_rd = 0;
  endtask

  task automatic step(input string nm, input logic [9:0] c, input logic [9:0] m,
                      input int s, input bit sc);
    exp_t e;
    e.nm = nm; e.ctl = c; e.mask = m; e.stall = s; e.schk = sc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    @(posedge clk);
    #1;
    // Reset outputs, with a forwarding match present that must be masked
    mem_valid = 1; mem_reg_wrenable = 1; mem_rd = 3; ex_rs1 = 3; mem_busy = 1;
    step("reset", C_RST, M_ALL, 0, 1);
    rst_n = 1'b1;

    clear_in(); id_valid = 1; id_rs1 = 1; id_uses_rs1 = 1;
    step("run_normal", C_RUN, M_ALL, 0, 1);

    clear_in(); ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wrenable = 1; ex_rd = 5;
    id_valid = 1; id_rs2 = 5; id_uses_rs2 = 1;
    step("load_use", C_LU, M_ALL, 0, 1);
    clear_in(); id_valid = 1; id_rs2 = 5; id_uses_rs2 = 1;
    step("after_load_use", C_RUN, M_ALL, 1, 1);

    clear_in(); ex_valid = 1; ex_mem_to_reg = 1; ex_rd = 0; id_valid = 1; id_uses_rs1 = 1;
    step("load_x0_no_stall", C_RUN, M_ALL, 1, 1);
    clear_in(); ex_valid = 1; ex_mem_to_reg = 1; ex_rd = 9; id_valid = 0; id_rs1 = 9; id_uses_rs1 = 1;
    step("load_id_invalid", C_RUN, M_ALL, 1, 1);

    clear_in(); mem_valid = 1; mem_reg_wrenable = 1; mem_rd = 3;
    wb_valid = 1; wb_reg_wrenable = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 0;
    step("fwd_mem_over_wb", C_RUN | F_A10, M_ALL, 1, 1);
    clear_in(); mem_valid = 1; mem_reg_wrenable = 1; mem_rd = 3; ex_rs1 = 3;
    wb_valid = 1; wb_reg_wrenable = 1; wb_rd = 7; ex_rs2 = 7;
    step("fwd_a_mem_b_wb", C_RUN | F_A10 | F_B01, M_ALL, 1, 1);
    clear_in(); mem_valid = 1; mem_reg_wrenable = 1; mem_rd = 0;
    wb_valid = 1; wb_reg_wrenable = 1; wb_rd = 0;
    step("fwd_x0", C_RUN, M_ALL, 1, 1);
    clear_in(); mem_valid = 1; mem_reg_wrenable = 0; mem_rd = 4; ex_rs1 = 4;
    wb_valid = 1; wb_reg_wrenable = 1; wb_rd = 4;
    step("fwd_mem_nowrite", C_RUN | F_A01, M_ALL, 1, 1);

    clear_in(); ex_valid = 1; ex_jump_taken = 1; ex_mem_to_reg = 1; ex_reg_wrenable = 1; ex_rd = 6;
    id_valid = 1; id_halt = 1; id_rs1 = 6; id_uses_rs1 = 1;
    step("redirect_priority", C_RED, M_NIE, 1, 1);
    clear_in(); id_valid = 1;
    step("after_redirect_run", C_RUN, M_ALL, 1, 1);

    clear_in(); mem_busy = 1; id_valid = 1; ex_valid = 1; ex_jump_taken = 1;
    step("freeze_over_redirect", C_FRZ, M_ALL, 1, 1);
    clear_in(); id_valid = 1;
    step("after_freeze", C_RUN, M_ALL, 2, 1);

    rst_n = 1'b0; clear_in();
    step("reset_pre_halt", C_RST, M_ALL, 0, 0);
    rst_n = 1'b1;

    clear_in(); id_valid = 1; id_halt = 1;
    step("halt_accept", C_HACC, M_NIE, 0, 1);
    clear_in(); ex_valid = 1; ex_jump_taken = 1; ex_mem_to_reg = 1; ex_rd = 5;
    id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1;
    step("drain1_ignores", C_DRN, M_DRN, 0, 1);
    clear_in(); mem_busy = 1;
    step("drain_frozen_a", C_DFZ, M_DFZ, 0, 1);
    step("drain_frozen_b", C_DFZ, M_DFZ, 1, 1);
    clear_in();
    step("drain2", C_DRN, M_DRN, 2, 1);
    step("drain3", C_DRN, M_DRN, 2, 1);
    step("halted_rise", C_HLT, M_ALL, 2, 1);
    mem_busy = 1; id_valid = 1; ex_valid = 1; ex_jump_taken = 1;
    step("halted_busy", C_HLT, M_ALL, 2, 1);
    clear_in();
    step("halted_hold", C_HLT, M_ALL, 2, 1);

    rst_n = 1'b0;
    step("reset_in_halted", C_RST, M_ALL, 0, 0);
    rst_n = 1'b1; id_valid = 1;
    step("resume_after_reset", C_RUN, M_ALL, 0, 1);

    clear_in(); mem_busy = 1;
    for (int i = 0; i < 20; i++)
      step("saturate_busy", C_FRZ, M_ALL, (i > 15) ? 15 : i, 1);
    clear_in(); id_valid = 1;
    step("saturate_hold_a", C_RUN, M_ALL, 15, 1);
    step("saturate_hold_b", C_RUN, M_ALL, 15, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_queue: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
